// File: rtl/rf_writeback.sv
// Register-file writeback stage: source select, load extension, 2-entry result buffer, RAW pending mask.
// Optional same-cycle bypass of an empty buffer is enabled by defining WB_BYPASS_EN.
module rf_writeback #(
   parameter int DEPTH          = 2,
   parameter int OPCODE_WIDTH   = 7,
   parameter int FUNCT3_LEN     = 3,
   parameter int SYS_REGS_WIDTH = 5,
   parameter int XLEN           = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      halt,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic [OPCODE_WIDTH-1:0]   opcode_in,
   input  logic [FUNCT3_LEN-1:0]     funct3_in,
   input  logic [SYS_REGS_WIDTH-1:0] rd_in,
   input  logic [XLEN-1:0]           alu_result,
   input  logic [XLEN-1:0]           load_data,
   input  logic [XLEN-1:0]           pc_plus4,
   output logic [SYS_REGS_WIDTH-1:0] rd_addr,
   output logic [XLEN-1:0]           write_data,
   output logic                      write_en,
   output logic [31:0]               pending_mask
);

   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
   localparam logic [FUNCT3_LEN-1:0]   FN3_SB    = 3'b000;
   localparam logic [FUNCT3_LEN-1:0]   FN3_SH    = 3'b001;
   localparam logic [FUNCT3_LEN-1:0]   FN3_SBU   = 3'b100;
   localparam logic [FUNCT3_LEN-1:0]   FN3_SHU   = 3'b101;

   logic [SYS_REGS_WIDTH-1:0] rd_mem_reg   [DEPTH];
   logic [XLEN-1:0]           data_mem_reg [DEPTH];
   logic                      wr_ptr_reg, rd_ptr_reg;
   logic [1:0]                count_reg, count_next;

   logic            writable, accept, bypass, push, pop, head_valid;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_ext, result;

   assign writable   = (opcode_in != OP_STORE) && (opcode_in != OP_BRANCH) && (rd_in != '0);
   assign ex_ready   = (count_reg < 2'd2);
   assign accept     = ex_valid & ex_ready;
   assign head_valid = (count_reg != 2'd0);

   always_comb begin
      byte_sel = 8'(load_data >> {alu_result[1:0], 3'b000});
      half_sel = alu_result[1] ? load_data[31:16] : load_data[15:0];
      case (funct3_in)
         FN3_SB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         FN3_SBU: load_ext = {24'd0, byte_sel};
         FN3_SH:  load_ext = {{16{half_sel[15]}}, half_sel};
         FN3_SHU: load_ext = {16'd0, half_sel};
         default: load_ext = load_data;
      endcase
   end

   always_comb begin
      if (opcode_in == OP_LOAD)
         result = load_ext;
      else if (opcode_in == OP_JAL || opcode_in == OP_JALR)
         result = pc_plus4;
      else
         result = alu_result;
   end

`ifdef WB_BYPASS_EN
   assign bypass = accept & writable & !head_valid & !halt;
`else
   assign bypass = 1'b0;
`endif

   assign push = accept & writable & !bypass;
   assign pop  = head_valid & !halt;

   always_comb begin
      rd_addr    = '0;
      write_data = '0;
      if (head_valid) begin
         rd_addr    = rd_mem_reg[rd_ptr_reg];
         write_data = data_mem_reg[rd_ptr_reg];
      end else if (bypass) begin
         rd_addr    = rd_in;
         write_data = result;
      end
   end
   assign write_en = pop | bypass;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      end
   end

   // Storage needs no reset: contents are only observed through count-qualified paths.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_reg[wr_ptr_reg]   <= rd_in;
         data_mem_reg[wr_ptr_reg] <= result;
      end
   end

   logic [31:0] mask_part [DEPTH];
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
         logic entry_valid;
         assign entry_valid   = (count_reg == 2'd2) || (head_valid && (rd_ptr_reg == 1'(gi)));
         assign mask_part[gi] = entry_valid ? (32'd1 << rd_mem_reg[gi]) : 32'd0;
      end
   endgenerate

   assign pending_mask = (mask_part[0] | mask_part[1]) & ~32'd1;

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: expected writes are queued at issue and
// matched against every write_en cycle observed on the falling edge.
module tb_rf_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halt;
   logic        ex_valid;
   logic        ex_ready;
   logic [6:0]  opcode_in;
   logic [2:0]  funct3_in;
   logic [4:0]  rd_in;
   logic [31:0] alu_result, load_data, pc_plus4;
   logic [4:0]  rd_addr;
   logic [31:0] write_data;
   logic        write_en;
   logic [31:0] pending_mask;

   int checks = 0;
   int errors = 0;
   logic [36:0] sb [$];

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   rf_writeback dut (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .opcode_in(opcode_in), .funct3_in(funct3_in), .rd_in(rd_in),
      .alu_result(alu_result), .load_data(load_data), .pc_plus4(pc_plus4),
      .rd_addr(rd_addr), .write_data(write_data), .write_en(write_en),
      .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Each cycle with write_en high is one register-file write.
   always @(negedge clk) begin
      if (write_en === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {27'd0, rd_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = sb.pop_front();
            chk("wr_rd", {27'd0, rd_addr}, {27'd0, e[36:32]});
            chk("wr_data", write_data, e[31:0]);
            $display("write x%0d = 0x%08h", rd_addr, write_data);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepts.
   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                       input bit wr, input logic [31:0] exp_data);
      bit done = 0;
      opcode_in = op; funct3_in = f3; rd_in = rd;
      alu_result = alu; load_data = ld; pc_plus4 = pc;
      ex_valid = 1'b1;
      if (wr) sb.push_back({rd, exp_data});
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (ex_ready) done = 1;
         @(posedge clk); #1;
      end
      ex_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, ld, pc;
      bit          wr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [$];

   initial begin
      rst_n = 1'b0; halt = 1'b0; ex_valid = 1'b0;
      opcode_in = '0; funct3_in = '0; rd_in = '0;
      alu_result = '0; load_data = '0; pc_plus4 = '0;
      #12;
      chk("rst_we", {31'd0, write_en}, 32'd0);
      chk("rst_rd", {27'd0, rd_addr}, 32'd0);
      chk("rst_data", write_data, 32'd0);
      chk("rst_mask", pending_mask, 32'd0);
      chk("rst_ready", {31'd0, ex_ready}, 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(2);

      vecs.push_back('{OP_LOAD, 3'b000, 5'd5, 32'h2, 32'h0080_0000, 32'h0, 1, 32'hFFFF_FF80});
      vecs.push_back('{OP_LOAD, 3'b101, 5'd6, 32'h2, 32'h8001_1234, 32'h0, 1, 32'h0000_8001});
      vecs.push_back('{OP_JAL,  3'b000, 5'd1, 32'h55, 32'h0, 32'h104, 1, 32'h0000_0104});
      vecs.push_back('{OP_STORE,3'b010, 5'd7, 32'h10, 32'h0, 32'h0, 0, 32'h0});
      vecs.push_back('{OP_IMM,  3'b000, 5'd0, 32'h99, 32'h0, 32'h0, 0, 32'h0});
      vecs.push_back('{OP_BR,   3'b000, 5'd3, 32'h1, 32'h0, 32'h0, 0, 32'h0});
      vecs.push_back('{OP_LOAD, 3'b100, 5'd8, 32'h3, 32'hF1F2_F3F4, 32'h0, 1, 32'h0000_00F1});
      vecs.push_back('{OP_LOAD, 3'b001, 5'd9, 32'h0, 32'h1234_8765, 32'h0, 1, 32'hFFFF_8765});
      vecs.push_back('{OP_LOAD, 3'b010, 5'd10, 32'h0, 32'hDEAD_BEEF, 32'h0, 1, 32'hDEAD_BEEF});
      vecs.push_back('{OP_LOAD, 3'b111, 5'd11, 32'h1, 32'hCAFE_0001, 32'h0, 1, 32'hCAFE_0001});
      vecs.push_back('{OP_JALR, 3'b000, 5'd12, 32'h0, 32'h0, 32'h2000, 1, 32'h0000_2000});
      vecs.push_back('{OP_IMM,  3'b000, 5'd31, 32'h7777, 32'h0, 32'h0, 1, 32'h0000_7777});
      foreach (vecs[i])
         send(vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].alu, vecs[i].ld, vecs[i].pc,
              vecs[i].wr, vecs[i].exp);
      idle(3);
      chk("idle_mask", pending_mask, 32'd0);
      chk("idle_sb_empty", sb.size(), 32'd0);

      // Halt: two results fill the buffer, a third waits for space.
      halt = 1'b1;
      send(OP_IMM, 3'b000, 5'd2, 32'h22, 32'h0, 32'h0, 1, 32'h22);
      send(OP_IMM, 3'b000, 5'd3, 32'h33, 32'h0, 32'h0, 1, 32'h33);
      opcode_in = OP_IMM; funct3_in = '0; rd_in = 5'd4; alu_result = 32'h44;
      ex_valid = 1'b1; sb.push_back({5'd4, 32'h44});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halt_ready", {31'd0, ex_ready}, 32'd0);
         chk("halt_we", {31'd0, write_en}, 32'd0);
         chk("halt_mask", pending_mask, 32'h0000_000C);
         chk("halt_head_rd", {27'd0, rd_addr}, 32'd2);
         @(posedge clk); #1;
      end
      halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bit acc;
         @(negedge clk);
         chk("drain_we", {31'd0, write_en}, 32'd1);
         chk("drain_rd", {27'd0, rd_addr}, 32'(2 + i));
         acc = ex_valid && ex_ready;
         @(posedge clk); #1;
         if (acc) ex_valid = 1'b0;
      end
      @(negedge clk);
      chk("drain_done_we", {31'd0, write_en}, 32'd0);
      chk("drain_done_mask", pending_mask, 32'd0);
      chk("drain_ready", {31'd0, ex_ready}, 32'd1);
      chk("drain_sb_empty", sb.size(), 32'd0);
      @(posedge clk); #1;

      // Reset with two buffered results: they must vanish.
      halt = 1'b1;
      send(OP_IMM, 3'b000, 5'd13, 32'h1313, 32'h0, 32'h0, 1, 32'h1313);
      send(OP_IMM, 3'b000, 5'd14, 32'h1414, 32'h0, 32'h0, 1, 32'h1414);
      #2;
      chk("pre_rst_mask", pending_mask, 32'h0000_6000);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, write_en}, 32'd0);
      chk("mid_rst_mask", pending_mask, 32'd0);
      chk("mid_rst_ready", {31'd0, ex_ready}, 32'd1);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1; halt = 1'b0;
      idle(5);
      chk("post_rst_mask", pending_mask, 32'd0);

      send(OP_IMM, 3'b000, 5'd15, 32'h1515, 32'h0, 32'h0, 1, 32'h1515);
      idle(3);
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
